// File: rtl/anim_pkg.sv
// anim_pkg: shared state encoding and default sizing for the circle animation controller
package anim_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam int N_DISP_DEF = 4;
  localparam int DIV_DEF = 25000000;
endpackage

// File: rtl/anim_tick_gen.sv
// anim_tick_gen: prescaler producing a one-cycle tick every DIV running cycles
module anim_tick_gen #(
  parameter int DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = run && (cnt_q == W'(DIV - 1));
  // count only while running, wrap after the tick cycle, clear on request
  always_comb cnt_d = (clr || tick) ? '0 : run ? cnt_q + 1'b1 : cnt_q;
  // prescaler register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/circle_anim_ctrl.sv
// circle_anim_ctrl: walks a circle around N_DISP seven-segment digits; CIRCLE_ANIM_DIR_EN enables the dir input
module circle_anim_ctrl
  import anim_pkg::*;
#(
  parameter int N_DISP = N_DISP_DEF,
  parameter int DIV = DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              hold,
  input  logic              dir,
  output logic [N_DISP-1:0] enable,
  output logic              pozitie,
  output logic              busy,
  output logic              lap
);
  localparam int SW = $clog2(2 * N_DISP);
  localparam logic [SW-1:0] LAST = SW'(2 * N_DISP - 1);
  state_t state_q, state_d;
  logic [SW-1:0] step_q, step_d, idx;
  logic [N_DISP-1:0] enable_q, enable_d;
  logic pozitie_q, busy_q, lap_q, lap_d;
  logic run, clr, tick, ccw, wrap;
`ifdef CIRCLE_ANIM_DIR_EN
  assign ccw = dir;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign ccw = 1'b0;
`endif
  assign run = (state_q == RUN) && !stop && !hold;
  assign clr = (state_q == IDLE) || stop;
  assign wrap = ccw ? (step_q == '0) : (step_q == LAST);
  anim_tick_gen #(.DIV(DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .run (run),
    .clr (clr),
    .tick(tick)
  );
  // next state and step; stop beats hold beats start
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    lap_d = 1'b0;
    case (state_q)
      IDLE: if (start && !stop) begin
        state_d = RUN;
        step_d = '0;
      end
      RUN: if (stop) state_d = IDLE;
      else if (hold) state_d = PAUSE;
      else if (tick) begin
        step_d = ccw ? (wrap ? LAST : step_q - 1'b1) : (wrap ? '0 : step_q + 1'b1);
        lap_d = wrap;
      end
      PAUSE: state_d = stop ? IDLE : hold ? PAUSE : RUN;
      default: state_d = IDLE;
    endcase
  end
  // upper half walks digits left to right, lower half walks back
  always_comb begin
    idx = (step_d < SW'(N_DISP)) ? step_d : LAST - step_d;
    enable_d = (state_d == IDLE) ? '0 : N_DISP'(1) << idx;
  end
  // state, step and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      step_q <= '0;
      enable_q <= '0;
      pozitie_q <= 1'b0;
      busy_q <= 1'b0;
      lap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      enable_q <= enable_d;
      pozitie_q <= (state_d != IDLE) && (step_d < SW'(N_DISP));
      busy_q <= state_d != IDLE;
      lap_q <= lap_d;
    end
  assign enable = enable_q;
  assign pozitie = pozitie_q;
  assign busy = busy_q;
  assign lap = lap_q;
endmodule

// File: tb/tb_circle_anim_ctrl.sv
// tb_circle_anim_ctrl: directed table and corner sequences for circle_anim_ctrl at N_DISP=4, DIV=4
module tb_circle_anim_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, hold = 1'b0, dir = 1'b0;
  logic [3:0] enable;
  logic pozitie, busy, lap;
  int total = 0, bad = 0;
  typedef struct {
    logic start, stop, hold, dir;
    logic [3:0] en;
    logic poz, busy, lap;
  } vec_t;
  vec_t tbl[33];
  logic [3:0] seq[8];
  circle_anim_ctrl #(.N_DISP(4), .DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold), .dir(dir),
    .enable(enable), .pozitie(pozitie), .busy(busy), .lap(lap)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [3:0] en, input logic poz, input logic bsy, input logic lp);
    total++;
    if (enable !== en || pozitie !== poz || busy !== bsy || lap !== lp) begin
      bad++;
      $display("FAIL %s: got en=%b poz=%b busy=%b lap=%b, want en=%b poz=%b busy=%b lap=%b",
               name, enable, pozitie, busy, lap, en, poz, bsy, lp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    tbl[0] = '{start: 1'b1, stop: 1'b0, hold: 1'b0, dir: 1'b0, en: 4'b0001, poz: 1'b1, busy: 1'b1, lap: 1'b0};
    for (int k = 1; k <= 32; k++)
      tbl[k] = '{start: 1'b0, stop: 1'b0, hold: 1'b0, dir: 1'b0, en: seq[(k / 4) % 8],
                 poz: ((k / 4) % 8) < 4, busy: 1'b1, lap: k == 32};
    repeat (2) cyc;
    check("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc;
    check("idle_wait", 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 33; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; hold = tbl[i].hold; dir = tbl[i].dir;
      cyc;
      check($sformatf("tbl[%0d]", i), tbl[i].en, tbl[i].poz, tbl[i].busy, tbl[i].lap);
    end
    repeat (2) cyc;
    check("pre_hold", 4'b0001, 1'b1, 1'b1, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc;
      check($sformatf("hold[%0d]", i), 4'b0001, 1'b1, 1'b1, 1'b0);
    end
    hold = 1'b0;
    cyc;
    check("resume0", 4'b0001, 1'b1, 1'b1, 1'b0);
    cyc;
    check("resume1", 4'b0001, 1'b1, 1'b1, 1'b0);
    cyc;
    check("resume_step", 4'b0010, 1'b1, 1'b1, 1'b0);
    start = 1'b1; stop = 1'b1;
    cyc;
    check("start_stop", 4'b0000, 1'b0, 1'b0, 1'b0);
    start = 1'b0; stop = 1'b0;
    cyc;
    check("stay_idle", 4'b0000, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cyc;
    check("dir_start", 4'b0001, 1'b1, 1'b1, 1'b0);
    start = 1'b0; dir = 1'b1;
    repeat (3) cyc;
    check("dir_mid", 4'b0001, 1'b1, 1'b1, 1'b0);
    cyc;
`ifdef CIRCLE_ANIM_DIR_EN
    check("dir_tick", 4'b0001, 1'b0, 1'b1, 1'b1);
`else
    check("dir_tick", 4'b0010, 1'b1, 1'b1, 1'b0);
`endif
    dir = 1'b0; stop = 1'b1;
    cyc;
    check("dir_stop", 4'b0000, 1'b0, 1'b0, 1'b0);
    stop = 1'b0; start = 1'b1;
    cyc;
    start = 1'b0;
    repeat (20) cyc;
    check("step5", 4'b0100, 1'b0, 1'b1, 1'b0);
    hold = 1'b1;
    cyc;
    check("pause5", 4'b0100, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check("async_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
    hold = 1'b0;
    cyc;
    check("rst_held", 4'b0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) cyc;
    check("post_rst_idle", 4'b0000, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cyc;
    check("restart", 4'b0001, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    repeat (4) cyc;
    check("restart_step", 4'b0010, 1'b1, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
